// File: rtl/alloc_mport_pkg.sv
// Shared types for the allocate/dispatch stage: uop payloads, ROB ids and the
// dispatch-port index carried by each alloc-buffer entry.
package alloc_mport_pkg;

    localparam int NUM_DISP_PORTS = 2;
    localparam int DISP_PORT_W    = (NUM_DISP_PORTS > 1) ? $clog2(NUM_DISP_PORTS) : 1;
    localparam int ROB_ID_W       = 6;
    localparam int PREG_W         = 6;

    typedef logic [DISP_PORT_W-1:0] t_disp_port;
    typedef logic [ROB_ID_W-1:0]    t_rob_id;
    typedef logic [PREG_W-1:0]      t_preg;

    localparam t_disp_port DISP_PORT_EINT = t_disp_port'(0);
    localparam t_disp_port DISP_PORT_MEM  = t_disp_port'(1);

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] imm;
    } t_uinstr;

    typedef struct packed {
        t_preg pdst;
        t_preg psrc1;
        t_preg psrc2;
    } t_rename_pkt;

    typedef struct packed {
        t_uinstr     uinstr;
        t_rob_id     robid;
        t_rename_pkt rename;
    } t_uinstr_disp;

    typedef struct packed {
        t_uinstr_disp disp;
        t_disp_port   port;
    } t_alloc_entry;

endpackage

// File: rtl/alloc_mport_q.sv
// Generic DEPTH-entry in-order queue with flush; DEPTH need not be a power of 2.
// Caller guarantees no enqueue when full and no dequeue when empty.
module alloc_q #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enq_i,
    input  T     enq_data_i,
    input  logic deq_i,
    input  logic flush_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    T                 mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (deq_i) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({enq_i, deq_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone says which slots hold live data.
    always_ff @(posedge clk) begin
        if (enq_i && !flush_i) mem_q[wr_ptr_q] <= enq_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/alloc_mport.sv
// Allocate/dispatch stage: tags RA0 uops with their ROB id, buffers them in
// order and steers the head to one of NUM_PORTS reservation-station ports.
module alloc_mport
    import alloc_mport_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_ra0,
    input  t_uinstr              uinstr_ra0,
    input  t_rename_pkt          rename_ra0,
    input  t_disp_port           port_ra0,
    input  t_rob_id              next_robid_ra0,
    output logic                 stall_ra0,
    input  logic                 flush,
    input  logic [NUM_PORTS-1:0] rs_stall_rs0,
    output logic [NUM_PORTS-1:0] disp_valid_rs0,
    output t_uinstr_disp         disp_rs0,
    output logic [CNT_W-1:0]     head_blk_cnt
);

    t_alloc_entry     enq_entry;
    t_alloc_entry     head;
    logic             enq, deq, full, empty, head_valid;
    logic             port_ok, head_rs_stall, head_blocked;
    logic [CNT_W-1:0] head_blk_cnt_q, head_blk_cnt_d;

    always_comb begin
        enq_entry.disp.uinstr = uinstr_ra0;
        enq_entry.disp.robid  = next_robid_ra0;
        enq_entry.disp.rename = rename_ra0;
        enq_entry.port        = port_ra0;
    end

    // Stall comes only from the occupancy flops, never from the RS stalls.
    assign stall_ra0  = full;
    assign enq        = valid_ra0 & ~stall_ra0 & ~flush;
    assign head_valid = ~empty;

    alloc_q #(
        .T     (t_alloc_entry),
        .DEPTH (DEPTH)
    ) u_q (
        .clk        (clk),
        .reset      (reset),
        .enq_i      (enq),
        .enq_data_i (enq_entry),
        .deq_i      (deq),
        .flush_i    (flush),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        disp_valid_rs0 = '0;
        port_ok        = 1'b0;
        head_rs_stall  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (head.port == t_disp_port'(p)) begin
                port_ok           = 1'b1;
                head_rs_stall     = rs_stall_rs0[p];
                disp_valid_rs0[p] = head_valid & ~rs_stall_rs0[p] & ~flush;
            end
        end
    end

    // An out-of-range port drains silently so the buffer cannot wedge.
    assign deq          = (|disp_valid_rs0) | (head_valid & ~port_ok & ~flush);
    assign head_blocked = head_valid & port_ok & head_rs_stall & ~flush;
    assign disp_rs0     = head.disp;

    always_comb begin
        head_blk_cnt_d = head_blk_cnt_q;
        if (head_blocked && head_blk_cnt_q != {CNT_W{1'b1}})
            head_blk_cnt_d = head_blk_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) head_blk_cnt_q <= '0;
        else       head_blk_cnt_q <= head_blk_cnt_d;
    end

    assign head_blk_cnt = head_blk_cnt_q;

    a_head_port_ok: assert property (@(posedge clk) disable iff (reset) head_valid |-> port_ok);

endmodule

// File: tb/tb_alloc_mport.sv
// Directed bench for alloc_mport: DEPTH=4 instance for the feature tests and a
// DEPTH=3 instance for pointer wrap under random RS backpressure.
module tb_alloc_mport;
    import alloc_mport_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=4 instance
    logic         valid_ra0, stall_ra0, flush;
    t_uinstr      uinstr_ra0;
    t_rename_pkt  rename_ra0;
    t_disp_port   port_ra0;
    t_rob_id      next_robid_ra0;
    logic [1:0]   rs_stall_rs0, disp_valid_rs0;
    t_uinstr_disp disp_rs0;
    logic [15:0]  head_blk_cnt;

    // DEPTH=3 instance
    logic         b_valid, b_stall, b_flush;
    t_uinstr      b_uinstr;
    t_rename_pkt  b_rename;
    t_disp_port   b_port;
    t_rob_id      b_robid;
    logic [1:0]   b_rs_stall, b_dv;
    t_uinstr_disp b_disp;
    logic [15:0]  b_cnt;

    alloc_mport #(.NUM_PORTS(2), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_ra0(valid_ra0), .uinstr_ra0(uinstr_ra0),
        .rename_ra0(rename_ra0), .port_ra0(port_ra0), .next_robid_ra0(next_robid_ra0),
        .stall_ra0(stall_ra0), .flush(flush), .rs_stall_rs0(rs_stall_rs0),
        .disp_valid_rs0(disp_valid_rs0), .disp_rs0(disp_rs0), .head_blk_cnt(head_blk_cnt)
    );

    alloc_mport #(.NUM_PORTS(2), .DEPTH(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .valid_ra0(b_valid), .uinstr_ra0(b_uinstr),
        .rename_ra0(b_rename), .port_ra0(b_port), .next_robid_ra0(b_robid),
        .stall_ra0(b_stall), .flush(b_flush), .rs_stall_rs0(b_rs_stall),
        .disp_valid_rs0(b_dv), .disp_rs0(b_disp), .head_blk_cnt(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input t_rob_id rid, input t_disp_port pt);
        valid_ra0        = v;
        next_robid_ra0   = rid;
        port_ra0         = pt;
        uinstr_ra0       = '{opcode: 8'h5A ^ 8'(rid), imm: 8'(rid)};
        rename_ra0       = '{pdst: t_preg'(rid + 1), psrc1: t_preg'(rid + 2), psrc2: t_preg'(rid + 3)};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        rs_stall_rs0 = 2'b00;
        b_valid = 1'b0; b_flush = 1'b0; b_rs_stall = 2'b00; b_port = '0; b_robid = '0;
        b_uinstr = '0; b_rename = '0;
        put(1'b1, 6'd5, DISP_PORT_EINT);
        tick();
        tick();
        checks++; if (stall_ra0 !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall_ra0); end
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL rst_dv got %b exp 00", disp_valid_rs0); end
        checks++; if (head_blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", head_blk_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL rst_rel_dv got %b exp 00", disp_valid_rs0); end
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b01) begin errors++; $display("FAIL rst_first_dv got %b exp 01", disp_valid_rs0); end
        checks++; if (disp_rs0.robid !== 6'd5) begin errors++; $display("FAIL rst_first_robid got %0d exp 5", disp_rs0.robid); end
        checks++; if (disp_rs0.rename.pdst !== 6'd6) begin errors++; $display("FAIL rst_first_pdst got %0d exp 6", disp_rs0.rename.pdst); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL rst_drained got %b exp 00", disp_valid_rs0); end
    endtask

    task automatic test_fill_block();
        rs_stall_rs0 = 2'b01;
        #1;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, t_rob_id'(10 + i), DISP_PORT_EINT);
            tick();
        end
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (stall_ra0 !== 1'b1) begin errors++; $display("FAIL fill_stall got %0b exp 1", stall_ra0); end
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL fill_dv got %b exp 00", disp_valid_rs0); end
        checks++; if (head_blk_cnt !== 16'd3) begin errors++; $display("FAIL fill_cnt3 got %0d exp 3", head_blk_cnt); end
        tick();
        tick();
        checks++; if (head_blk_cnt !== 16'd5) begin errors++; $display("FAIL fill_cnt5 got %0d exp 5", head_blk_cnt); end
        rs_stall_rs0 = 2'b00;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (disp_valid_rs0 !== 2'b01) begin errors++; $display("FAIL drain_dv[%0d] got %b exp 01", i, disp_valid_rs0); end
            checks++; if (disp_rs0.robid !== t_rob_id'(10 + i)) begin errors++; $display("FAIL drain_robid[%0d] got %0d exp %0d", i, disp_rs0.robid, 10 + i); end
            tick();
        end
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL drain_empty got %b exp 00", disp_valid_rs0); end
        checks++; if (stall_ra0 !== 1'b0) begin errors++; $display("FAIL drain_stall got %0b exp 0", stall_ra0); end
        checks++; if (head_blk_cnt !== 16'd5) begin errors++; $display("FAIL drain_cnt got %0d exp 5", head_blk_cnt); end
    endtask

    task automatic test_ordering();
        rs_stall_rs0 = 2'b01;
        put(1'b1, 6'd20, DISP_PORT_EINT);
        tick();
        put(1'b1, 6'd21, DISP_PORT_MEM);
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL ord_blk0 got %b exp 00", disp_valid_rs0); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL ord_blk1 got %b exp 00", disp_valid_rs0); end
        checks++; if (head_blk_cnt !== 16'd7) begin errors++; $display("FAIL ord_cnt got %0d exp 7", head_blk_cnt); end
        rs_stall_rs0 = 2'b00;
        #1;
        checks++; if (disp_valid_rs0 !== 2'b01 || disp_rs0.robid !== 6'd20) begin errors++; $display("FAIL ord_a got dv=%b robid=%0d exp dv=01 robid=20", disp_valid_rs0, disp_rs0.robid); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b10 || disp_rs0.robid !== 6'd21) begin errors++; $display("FAIL ord_b got dv=%b robid=%0d exp dv=10 robid=21", disp_valid_rs0, disp_rs0.robid); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL ord_empty got %b exp 00", disp_valid_rs0); end
    endtask

    task automatic test_full_deq();
        rs_stall_rs0 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, t_rob_id'(30 + i), DISP_PORT_EINT);
            tick();
        end
        put(1'b1, 6'd34, DISP_PORT_EINT);
        rs_stall_rs0 = 2'b00;
        #1;
        checks++; if (stall_ra0 !== 1'b1) begin errors++; $display("FAIL fd_stall got %0b exp 1", stall_ra0); end
        checks++; if (disp_valid_rs0 !== 2'b01 || disp_rs0.robid !== 6'd30) begin errors++; $display("FAIL fd_head got dv=%b robid=%0d exp dv=01 robid=30", disp_valid_rs0, disp_rs0.robid); end
        tick();
        checks++; if (dut.u_q.count_q !== 3'd3) begin errors++; $display("FAIL fd_count got %0d exp 3", dut.u_q.count_q); end
        checks++; if (stall_ra0 !== 1'b0) begin errors++; $display("FAIL fd_unstall got %0b exp 0", stall_ra0); end
        checks++; if (disp_rs0.robid !== 6'd31) begin errors++; $display("FAIL fd_r31 got %0d exp 31", disp_rs0.robid); end
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (dut.u_q.count_q !== 3'd3) begin errors++; $display("FAIL fd_count_same got %0d exp 3", dut.u_q.count_q); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (disp_valid_rs0 !== 2'b01 || disp_rs0.robid !== t_rob_id'(32 + i)) begin errors++; $display("FAIL fd_drain[%0d] got dv=%b robid=%0d exp dv=01 robid=%0d", i, disp_valid_rs0, disp_rs0.robid, 32 + i); end
            tick();
        end
        checks++; if (disp_valid_rs0 !== 2'b00 || dut.u_q.count_q !== 3'd0) begin errors++; $display("FAIL fd_empty got dv=%b count=%0d exp dv=00 count=0", disp_valid_rs0, dut.u_q.count_q); end
        checks++; if (head_blk_cnt !== 16'd10) begin errors++; $display("FAIL fd_cnt got %0d exp 10", head_blk_cnt); end
    endtask

    task automatic test_flush();
        rs_stall_rs0 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, t_rob_id'(40 + i), DISP_PORT_EINT);
            tick();
        end
        rs_stall_rs0 = 2'b00;
        flush = 1'b1;
        put(1'b1, 6'd50, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL fl_dv got %b exp 00", disp_valid_rs0); end
        tick();
        flush = 1'b0;
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (dut.u_q.count_q !== 3'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", dut.u_q.count_q); end
        checks++; if (dut.u_q.rd_ptr_q !== 2'd0 || dut.u_q.wr_ptr_q !== 2'd0) begin errors++; $display("FAIL fl_ptrs got rd=%0d wr=%0d exp 0 0", dut.u_q.rd_ptr_q, dut.u_q.wr_ptr_q); end
        checks++; if (disp_valid_rs0 !== 2'b00 || stall_ra0 !== 1'b0) begin errors++; $display("FAIL fl_idle got dv=%b stall=%0b exp 00 0", disp_valid_rs0, stall_ra0); end
        checks++; if (head_blk_cnt !== 16'd12) begin errors++; $display("FAIL fl_cnt got %0d exp 12", head_blk_cnt); end
        put(1'b1, 6'd51, DISP_PORT_MEM);
        tick();
        put(1'b1, 6'd52, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b10 || disp_rs0.robid !== 6'd51) begin errors++; $display("FAIL fl_post0 got dv=%b robid=%0d exp dv=10 robid=51", disp_valid_rs0, disp_rs0.robid); end
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b01 || disp_rs0.robid !== 6'd52) begin errors++; $display("FAIL fl_post1 got dv=%b robid=%0d exp dv=01 robid=52", disp_valid_rs0, disp_rs0.robid); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL fl_empty got %b exp 00", disp_valid_rs0); end
    endtask

    task automatic test_reset_mid();
        rs_stall_rs0 = 2'b11;
        put(1'b1, 6'd60, DISP_PORT_EINT);
        tick();
        put(1'b1, 6'd61, DISP_PORT_EINT);
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (head_blk_cnt !== 16'd13) begin errors++; $display("FAIL rm_cnt_pre got %0d exp 13", head_blk_cnt); end
        #2;
        rs_stall_rs0 = 2'b00;
        reset = 1'b1;
        #1;
        checks++; if (disp_valid_rs0 !== 2'b00 || stall_ra0 !== 1'b0) begin errors++; $display("FAIL rm_out got dv=%b stall=%0b exp 00 0", disp_valid_rs0, stall_ra0); end
        checks++; if (head_blk_cnt !== 16'd0 || dut.u_q.count_q !== 3'd0) begin errors++; $display("FAIL rm_state got cnt=%0d count=%0d exp 0 0", head_blk_cnt, dut.u_q.count_q); end
        tick();
        reset = 1'b0;
        put(1'b1, 6'd7, DISP_PORT_MEM);
        tick();
        put(1'b0, 6'd0, DISP_PORT_EINT);
        checks++; if (disp_valid_rs0 !== 2'b10 || disp_rs0.robid !== 6'd7) begin errors++; $display("FAIL rm_resume got dv=%b robid=%0d exp dv=10 robid=7", disp_valid_rs0, disp_rs0.robid); end
        tick();
        checks++; if (disp_valid_rs0 !== 2'b00) begin errors++; $display("FAIL rm_empty got %b exp 00", disp_valid_rs0); end
    endtask

    typedef struct packed {
        t_rob_id    robid;
        t_disp_port port;
    } t_sb_entry;

    task automatic test_wrap();
        t_sb_entry sb[$];
        t_sb_entry item;
        int        sent = 0;
        int        done = 0;
        logic      model_full;
        logic [1:0] exp_dv;
        for (int cyc = 0; cyc < 300 && done < 10; cyc++) begin
            b_rs_stall = 2'($urandom_range(0, 3));
            if (sent < 10) begin
                if (!b_valid || b_robid != t_rob_id'(sent + 1)) b_port = t_disp_port'($urandom_range(0, 1));
                b_valid  = 1'b1;
                b_robid  = t_rob_id'(sent + 1);
                b_uinstr = '{opcode: 8'(sent), imm: 8'h00};
                b_rename = '{pdst: t_preg'(sent), psrc1: '0, psrc2: '0};
            end else begin
                b_valid = 1'b0;
            end
            #1;
            model_full = (sb.size() == 3);
            exp_dv = 2'b00;
            if (sb.size() > 0 && !b_rs_stall[sb[0].port]) exp_dv = 2'b01 << sb[0].port;
            checks++; if (b_stall !== model_full) begin errors++; $display("FAIL wrap_stall c%0d got %0b exp %0b", cyc, b_stall, model_full); end
            checks++; if (b_dv !== exp_dv) begin errors++; $display("FAIL wrap_dv c%0d got %b exp %b", cyc, b_dv, exp_dv); end
            if (exp_dv != 2'b00) begin
                item = sb.pop_front();
                done++;
                checks++; if (b_disp.robid !== item.robid) begin errors++; $display("FAIL wrap_robid c%0d got %0d exp %0d", cyc, b_disp.robid, item.robid); end
            end
            if (b_valid && !model_full) begin
                sb.push_back('{robid: b_robid, port: b_port});
                sent++;
            end
            tick();
        end
        b_valid = 1'b0;
        checks++; if (done != 10) begin errors++; $display("FAIL wrap_timeout got %0d dispatched exp 10", done); end
    endtask

    initial begin
        test_reset();
        test_fill_block();
        test_ordering();
        test_full_deq();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
